load_store_unit: RTL and testbench

Multi-cycle load/store stage downstream of the ALU: takes the effective address from the ALU, runs one data-memory transaction over a req/ready handshake, and returns sign- or zero-extended load data to register writeback. For stores it handles byte-lane steering and strobes. It stalls the core (`busy`) while a transaction is outstanding, and it bounds every transaction with a timeout.

---
 rtl/load_store_unit.sv | 126 ++++++++++++
 tb/tb_load_store_unit.sv | 129 ++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: single-transaction load/store stage with byte-lane steering, extension and bus timeout.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [6:0]       opcode,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] Mem_addr,
  input  logic [WIDTH-1:0] RS2,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] load_data,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, load_data_q, load_data_d;
  logic [3:0] strb_q, strb_d;
  logic [1:0] size_q, size_d;
  logic uns_q, uns_d, we_q, we_d, err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic is_ld, is_st, bad_f3, misalign;
  logic [1:0] eff_o;
  logic [7:0] byte_sel;
  logic [15:0] half_sel;
  logic [WIDTH-1:0] ext, wdata_in;
  logic [3:0] strb_in;
  assign is_ld  = opcode == 7'b0000011;
  assign is_st  = opcode == 7'b0100011;
  assign bad_f3 = is_ld ? (&Funct3[1:0] || Funct3 == 3'b110) : (Funct3[2] || &Funct3[1:0]);
`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = (Funct3[1:0] == 2'b01 && Mem_addr[0]) || (Funct3[1:0] == 2'b10 && Mem_addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif
  // Misaligned halfword/word offsets are forced aligned before capture.
  assign eff_o    = Funct3[1] ? 2'b00 : Funct3[0] ? {Mem_addr[1], 1'b0} : Mem_addr[1:0];
  assign strb_in  = !is_st ? 4'h0 : Funct3[1] ? 4'hf : (Funct3[0] ? 4'b0011 : 4'b0001) << eff_o;
  assign wdata_in = Funct3[1] ? RS2 : Funct3[0] ? {2{RS2[15:0]}} : {4{RS2[7:0]}};
  assign byte_sel = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  assign ext = size_q == 2'b00 ? {{24{~uns_q & byte_sel[7]}}, byte_sel}
             : size_q == 2'b01 ? {{16{~uns_q & half_sel[15]}}, half_sel} : mem_rdata;
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    strb_d      = strb_q;
    size_d      = size_q;
    uns_d       = uns_q;
    we_d        = we_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    load_data_d = load_data_q;
    case (state_q)
      IDLE: if (start && (is_ld || is_st)) begin
        state_d = (bad_f3 || misalign) ? DONE : REQ;
        err_d   = bad_f3 || misalign;
        addr_d  = {Mem_addr[WIDTH-1:2], eff_o};
        wdata_d = wdata_in;
        strb_d  = strb_in;
        size_d  = Funct3[1:0];
        uns_d   = Funct3[2];
        we_d    = is_st;
        cnt_d   = '0;
      end
      REQ: if (mem_ready) begin
        state_d     = DONE;
        err_d       = 1'b0;
        load_data_d = we_q ? load_data_q : ext;
      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
        state_d = DONE;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      strb_q      <= strb_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      we_q        <= we_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      load_data_q <= load_data_d;
    end
  end
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign err       = done & err_q;
  assign mem_req   = state_q == REQ;
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = mem_req ? {addr_q[WIDTH-1:2], 2'b00} : '0;
  assign mem_wdata = mem_req ? wdata_q : '0;
  assign mem_wstrb = mem_req ? strb_q : 4'h0;
  assign load_data = load_data_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven directed vectors plus hand-written timeout and reset sequences.
module tb_load_store_unit;
  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, mem_ready = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] Funct3 = '0;
  logic [31:0] Mem_addr = '0, RS2 = '0, mem_rdata = '0;
  logic busy, done, err, mem_req, mem_we;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [3:0] mem_wstrb;
  int n_vec = 0, n_bad = 0;
  always #5 clk = ~clk;
  load_store_unit dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .Funct3(Funct3),
    .Mem_addr(Mem_addr), .RS2(RS2), .busy(busy), .done(done), .err(err),
    .load_data(load_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );
  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr, rs2, rdata;
    int          dly;
    logic        bus;
    logic [31:0] eaddr, ewdata;
    logic [3:0]  estrb;
    logic        eerr;
    logic [31:0] eld;
  } vec_t;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam logic M_BUS = 1'b0, M_ERR = 1'b1;
  localparam logic [31:0] L9 = 32'h0000F234, L10 = 32'h0000F234;
`else
  localparam logic M_BUS = 1'b1, M_ERR = 1'b0;
  localparam logic [31:0] L9 = 32'h11223344, L10 = 32'hFFFFABCD;
`endif
  vec_t v[13];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d, input logic [31:0] rd);
    @(negedge clk);
    start = 1'b1; opcode = op; Funct3 = f3; Mem_addr = a; RS2 = d; mem_rdata = rd;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  initial begin
    int n;
    v[0]  = '{0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1, 32'h100, 32'h0, 4'h0, 0, 32'hDEADBEEF};
    v[1]  = '{0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 0, 1, 32'h100, 32'h0, 4'h0, 0, 32'hFFFFFF80};
    v[2]  = '{0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 0, 1, 32'h100, 32'h0, 4'h0, 0, 32'h00000080};
    v[3]  = '{0, 3'b001, 32'h102, 32'h0, 32'h80011234, 2, 1, 32'h100, 32'h0, 4'h0, 0, 32'hFFFF8001};
    v[4]  = '{0, 3'b101, 32'h100, 32'h0, 32'h8001F234, 0, 1, 32'h100, 32'h0, 4'h0, 0, 32'h0000F234};
    v[5]  = '{1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 0, 1, 32'h100, 32'hABCDABCD, 4'b1100, 0, 32'h0000F234};
    v[6]  = '{1, 3'b000, 32'h201, 32'h000000A5, 32'h0, 1, 1, 32'h200, 32'hA5A5A5A5, 4'b0010, 0, 32'h0000F234};
    v[7]  = '{1, 3'b010, 32'h040, 32'hCAFEF00D, 32'h0, 0, 1, 32'h040, 32'hCAFEF00D, 4'b1111, 0, 32'h0000F234};
    v[8]  = '{0, 3'b010, 32'h101, 32'h0, 32'h11223344, 0, M_BUS, 32'h100, 32'h0, 4'h0, M_ERR, L9};
    v[9]  = '{0, 3'b001, 32'h103, 32'h0, 32'hABCD0000, 0, M_BUS, 32'h100, 32'h0, 4'h0, M_ERR, L10};
    v[10] = '{0, 3'b011, 32'h000, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 1, L10};
    v[11] = '{1, 3'b100, 32'h000, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 1, L10};
    v[12] = '{0, 3'b010, 32'h300, 32'h0, 32'h0BADF00D, 15, 1, 32'h300, 32'h0, 4'h0, 0, 32'h0BADF00D};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_err", err, 0);
    chk("rst_req", mem_req, 0); chk("rst_ld", load_data, 0); chk("rst_strb", mem_wstrb, 0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 13; i++) begin
      issue(v[i].st ? ST : LD, v[i].f3, v[i].addr, v[i].rs2, v[i].rdata);
      if (v[i].bus) begin
        chk($sformatf("v%0d_req", i), mem_req, 1);
        chk($sformatf("v%0d_addr", i), mem_addr, v[i].eaddr);
        chk($sformatf("v%0d_we", i), mem_we, v[i].st);
        chk($sformatf("v%0d_strb", i), mem_wstrb, v[i].estrb);
        if (v[i].st) chk($sformatf("v%0d_wdata", i), mem_wdata, v[i].ewdata);
        for (int d = 0; d < v[i].dly; d++) begin
          @(posedge clk);
          #1 chk($sformatf("v%0d_stall_addr", i), {31'b0, mem_req} + mem_addr, 32'd1 + v[i].eaddr);
        end
        mem_ready = 1'b1;
        @(posedge clk);
        #1 mem_ready = 1'b0;
      end else begin
        chk($sformatf("v%0d_noreq", i), mem_req, 0);
      end
      chk($sformatf("v%0d_done", i), done, 1);
      chk($sformatf("v%0d_err", i), err, v[i].eerr);
      chk($sformatf("v%0d_ld", i), load_data, v[i].eld);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_drop", i), done, 0);
      chk($sformatf("v%0d_idle", i), busy, 0);
    end
    // Non-memory opcode must be ignored.
    issue(7'b0110011, 3'b010, 32'h100, 32'h0, 32'h0);
    chk("badop_busy", busy, 0);
    // Store timeout: mem_ready held low.
    issue(ST, 3'b010, 32'h40, 32'h12345678, 32'h0);
    n = 0;
    while (mem_req && n < 40) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk("to_req_cycles", n, 16);
    chk("to_done", done, 1);
    chk("to_err", err, 1);
    chk("to_ld", load_data, 32'h0BADF00D);
    // Asynchronous reset while stalled in REQ.
    issue(LD, 3'b010, 32'h100, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_req", mem_req, 0); chk("arst_busy", busy, 0);
    chk("arst_done", done, 0); chk("arst_ld", load_data, 0);
    @(negedge clk) rst = 1'b0;
    issue(LD, 3'b010, 32'h0, 32'h0, 32'h5A5A5A5A);
    chk("post_req", mem_req, 1);
    mem_ready = 1'b1;
    @(posedge clk);
    #1 mem_ready = 1'b0;
    chk("post_done", done, 1); chk("post_err", err, 0); chk("post_ld", load_data, 32'h5A5A5A5A);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
